// File: rtl/seven_spin_seq.sv
// -----------------------------------------------------------------------------
// seven_spin_seq
//
// Purpose:
//   Drives a multiplexed seven-segment display with a nine-frame "spin"
//   animation. A prescaler generates a scan tick that walks one active-low
//   anode across the digits. After FRAME_SCANS full sweeps the animation frame
//   steps up (dir=0, 8 -> 0 wrap) or down (dir=1, 0 -> 8 wrap). The pattern
//   output is a 4-bit index into an external segment decoder; 4'hF is blank.
//
// Parameters:
//   DIGITS      number of multiplexed digits (2..8)
//   TICK_DIV    clk cycles per digit scan step (>= 2)
//   FRAME_SCANS full digit sweeps per animation frame (>= 1)
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   enable       in   run animation and scan when high
//   pause        in   freeze frame advance; scanning continues
//   dir          in   0 = frame counts up, 1 = frame counts down
//   an           out  [DIGITS-1:0] active-low anode select (registered)
//   pattern      out  [3:0] pattern index, 4'hF = blank (registered)
//   frame        out  [3:0] current animation frame 0..8 (registered)
//   frame_strobe out  one-cycle pulse coincident with each frame change
//
// Build option:
//   SEVEN_SPIN_OFFSET_EN  defined   -> pattern = (frame + digit) mod 9
//                         undefined -> pattern = frame on every digit
// -----------------------------------------------------------------------------
module seven_spin_seq #(
   parameter int unsigned DIGITS      = 8,
   parameter int unsigned TICK_DIV    = 100000,
   parameter int unsigned FRAME_SCANS = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              pause,
   input  logic              dir,
   output logic [DIGITS-1:0] an,
   output logic [3:0]        pattern,
   output logic [3:0]        frame,
   output logic              frame_strobe
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned SW = (FRAME_SCANS > 1) ? $clog2(FRAME_SCANS) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);
   localparam logic [SW-1:0] SWEEP_LAST = SW'(FRAME_SCANS - 1);

   localparam logic [3:0] FRAME_LAST = 4'd8;
   localparam logic [3:0] BLANK      = 4'hF;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StHold = 2'd2
   } state_e;

   state_e state_q, state_d;

   logic [PW-1:0]     presc_q, presc_d;
   logic [DW-1:0]     digit_q, digit_d;
   logic [SW-1:0]     sweep_q, sweep_d;
   logic [3:0]        frame_q, frame_d;
   logic              strobe_q, strobe_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [3:0]        pattern_q, pattern_d;

   logic tick;
   logic digit_wrap;
   logic sweep_wrap;
   logic advance;
   logic [3:0] pattern_idx;

   // ---------------------------------------------------------------------------
   // Control FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (enable) state_d = StRun;
         end
         StRun: begin
            if (!enable)    state_d = StIdle;
            else if (pause) state_d = StHold;
         end
         StHold: begin
            if (!enable)     state_d = StIdle;
            else if (!pause) state_d = StRun;
         end
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Scan timing. Counters only run once the FSM is already out of idle, so
   // the first tick lands TICK_DIV cycles after entering RUN. They are cleared
   // on the same edge that returns to idle.
   // ---------------------------------------------------------------------------
   assign tick       = (state_q != StIdle) && (presc_q == PRESC_LAST);
   assign digit_wrap = tick && (digit_q == DIGIT_LAST);
   assign sweep_wrap = digit_wrap && (sweep_q == SWEEP_LAST);

   // Pause wins over a coincident sweep wrap; HOLD never advances.
   assign advance = (state_q == StRun) && sweep_wrap && !pause && enable;

   always_comb begin
      presc_d = presc_q;
      digit_d = digit_q;
      sweep_d = sweep_q;
      if (state_d == StIdle) begin
         presc_d = '0;
         digit_d = '0;
         sweep_d = '0;
      end else if (state_q != StIdle) begin
         if (tick) begin
            presc_d = '0;
            if (digit_wrap) begin
               digit_d = '0;
               if (sweep_wrap) sweep_d = '0;
               else            sweep_d = sweep_q + 1'b1;
            end else begin
               digit_d = digit_q + 1'b1;
            end
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Frame counter, mod 9 in either direction. dir is only looked at here.
   // ---------------------------------------------------------------------------
   always_comb begin
      frame_d  = frame_q;
      strobe_d = 1'b0;
      if (advance) begin
         strobe_d = 1'b1;
         if (dir) begin
            frame_d = (frame_q == 4'd0) ? FRAME_LAST : frame_q - 4'd1;
         end else begin
            frame_d = (frame_q >= FRAME_LAST) ? 4'd0 : frame_q + 4'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Pattern index. Built from next-state values so the registered outputs
   // line up with the digit and frame registers on the same edge.
   // ---------------------------------------------------------------------------
`ifdef SEVEN_SPIN_OFFSET_EN
   logic [3:0] offset_sum;
   // frame <= 8 and digit <= 7, so the sum fits in 4 bits; one subtract wraps.
   assign offset_sum  = frame_d + 4'(digit_d);
   assign pattern_idx = (offset_sum >= 4'd9) ? (offset_sum - 4'd9) : offset_sum;
`else
   assign pattern_idx = frame_d;
`endif

   always_comb begin
      an_d      = '1;
      pattern_d = BLANK;
      if (state_d != StIdle) begin
         an_d[digit_d] = 1'b0;
         pattern_d     = pattern_idx;
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         presc_q   <= '0;
         digit_q   <= '0;
         sweep_q   <= '0;
         frame_q   <= 4'd0;
         strobe_q  <= 1'b0;
         an_q      <= '1;
         pattern_q <= BLANK;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         digit_q   <= digit_d;
         sweep_q   <= sweep_d;
         frame_q   <= frame_d;
         strobe_q  <= strobe_d;
         an_q      <= an_d;
         pattern_q <= pattern_d;
      end
   end

   assign an           = an_q;
   assign pattern      = pattern_q;
   assign frame        = frame_q;
   assign frame_strobe = strobe_q;

endmodule

// File: tb/tb_seven_spin_seq.sv
// -----------------------------------------------------------------------------
// tb_seven_spin_seq
//
// Purpose:
//   Self-checking bench for seven_spin_seq with DIGITS=4, TICK_DIV=4,
//   FRAME_SCANS=2 (one frame = 32 clk cycles). Expected frame changes and
//   anode steps are queued by the stimulus; monitors pop and compare when the
//   DUT pulses frame_strobe or changes an. Honours SEVEN_SPIN_OFFSET_EN for
//   the per-digit pattern expectation.
// -----------------------------------------------------------------------------
module tb_seven_spin_seq;

   localparam int DIGITS      = 4;
   localparam int TICK_DIV    = 4;
   localparam int FRAME_SCANS = 2;
   localparam int FRAME_CYC   = DIGITS * TICK_DIV * FRAME_SCANS;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        pause;
   logic        dir;
   logic [3:0]  an;
   logic [3:0]  pattern;
   logic [3:0]  frame;
   logic        frame_strobe;

   int total = 0;
   int bad   = 0;

   logic [3:0] exp_frame_q[$];
   logic [3:0] exp_an_q[$];
   logic [3:0] an_prev = 4'hF;
   int         an_changes = 0;

   seven_spin_seq #(
      .DIGITS      (DIGITS),
      .TICK_DIV    (TICK_DIV),
      .FRAME_SCANS (FRAME_SCANS)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .pause        (pause),
      .dir          (dir),
      .an           (an),
      .pattern      (pattern),
      .frame        (frame),
      .frame_strobe (frame_strobe)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitors on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (frame_strobe === 1'b1) begin
         if (exp_frame_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe: got frame %0d expected no strobe (t=%0t)",
                     frame, $time);
         end else begin
            check("strobe_frame", {28'd0, frame}, {28'd0, exp_frame_q.pop_front()});
         end
      end
      if (an !== an_prev) begin
         an_changes++;
         if (exp_an_q.size() > 0) check("an_step", {28'd0, an}, {28'd0, exp_an_q.pop_front()});
         an_prev = an;
      end
   end

   // Counts rising edges until frame_strobe is seen, sampled #1 after the edge.
   task automatic wait_strobe(input int budget, output int n);
      n = 0;
      while (1) begin
         @(posedge clk);
         #1;
         n++;
         if (frame_strobe === 1'b1 || n >= budget) break;
      end
      if (frame_strobe !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL strobe_timeout: got none after %0d cycles expected a strobe", n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      int         c0;
      int         cyc;
      logic [3:0] want_an;
      logic [3:0] want_pat;

      enable = 1'b0;
      pause  = 1'b0;
      dir    = 1'b0;
      rst_n  = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      // Reset values appear before any clock edge.
      check("reset_an", {28'd0, an}, 32'hF);
      check("reset_pattern", {28'd0, pattern}, 32'hF);
      check("reset_frame", {28'd0, frame}, 32'd0);
      check("reset_strobe", {31'd0, frame_strobe}, 32'd0);

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_an", {28'd0, an}, 32'hF);

      // Scan order and first frame step at 32 cycles.
      exp_an_q.push_back(4'b1110);
      exp_an_q.push_back(4'b1101);
      exp_an_q.push_back(4'b1011);
      exp_an_q.push_back(4'b0111);
      exp_an_q.push_back(4'b1110);
      exp_an_q.push_back(4'b1101);
      exp_an_q.push_back(4'b1011);
      exp_an_q.push_back(4'b0111);
      exp_frame_q.push_back(4'd1);
      enable = 1'b1;
      @(posedge clk);
      #1;
      check("run_pattern", {28'd0, pattern}, 32'd0);
      wait_strobe(FRAME_CYC + 8, n);
      check("first_frame_cycles", n, FRAME_CYC);

      // Count up through 8 and wrap to 0.
      for (int f = 2; f <= 9; f++) begin
         exp_frame_q.push_back(4'(f % 9));
         wait_strobe(FRAME_CYC + 8, n);
         check("up_frame_cycles", n, FRAME_CYC);
      end
      check("up_wrap_frame", {28'd0, frame}, 32'd0);

      // Count down from 0 wraps to 8.
      dir = 1'b1;
      exp_frame_q.push_back(4'd8);
      wait_strobe(FRAME_CYC + 8, n);
      check("down_wrap_frame", {28'd0, frame}, 32'd8);

      // dir changed mid-frame applies to the next advance.
      repeat (10) @(posedge clk);
      #1 dir = 1'b0;
      exp_frame_q.push_back(4'd0);
      wait_strobe(FRAME_CYC + 8, n);
      check("mid_dir_cycles", n, FRAME_CYC - 10);

      // Pause across a sweep wrap: no advance, scanning continues.
      c0    = an_changes;
      pause = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("hold_frame", {28'd0, frame}, 32'd0);
      check("hold_scanning", {31'd0, (an_changes - c0) >= 8}, 32'd1);
      pause = 1'b0;
      exp_frame_q.push_back(4'd1);
      wait_strobe(FRAME_CYC + 8, n);
      check("release_cycles", n, 24);

      // Pause only in the wrap cycle still blocks the advance.
      repeat (FRAME_CYC - 1) @(posedge clk);
      #1 pause = 1'b1;
      @(posedge clk);
      #1 pause = 1'b0;
      exp_frame_q.push_back(4'd2);
      wait_strobe(FRAME_CYC + 8, n);
      check("precedence_cycles", n, FRAME_CYC);

      // Reach frame 7 and check per-digit pattern.
      for (int f = 3; f <= 7; f++) begin
         exp_frame_q.push_back(4'(f));
         wait_strobe(FRAME_CYC + 8, n);
      end
      for (int k = 0; k < DIGITS; k++) begin
         want_an = ~(4'b0001 << k);
`ifdef SEVEN_SPIN_OFFSET_EN
         want_pat = 4'((7 + k) % 9);
`else
         want_pat = 4'd7;
`endif
         cyc = 0;
         while (an !== want_an && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
         end
         check("digit_an", {28'd0, an}, {28'd0, want_an});
         check("digit_pattern", {28'd0, pattern}, {28'd0, want_pat});
      end

      // Down to 5, then drop enable mid-frame.
      dir = 1'b1;
      exp_frame_q.push_back(4'd6);
      wait_strobe(FRAME_CYC + 24, n);
      exp_frame_q.push_back(4'd5);
      wait_strobe(FRAME_CYC + 8, n);
      repeat (10) @(posedge clk);
      #1 enable = 1'b0;
      @(posedge clk);
      #1;
      check("drop_an", {28'd0, an}, 32'hF);
      check("drop_pattern", {28'd0, pattern}, 32'hF);
      check("drop_frame", {28'd0, frame}, 32'd5);
      repeat (5) @(posedge clk);
      #1;
      check("idle_hold_an", {28'd0, an}, 32'hF);
      enable = 1'b1;
      @(posedge clk);
      #1;
      check("reenable_an", {28'd0, an}, 32'hE);
      check("reenable_pattern", {28'd0, pattern}, 32'd5);
      exp_frame_q.push_back(4'd4);
      wait_strobe(FRAME_CYC + 8, n);
      check("reenable_cycles", n, FRAME_CYC);

      // Asynchronous reset mid-RUN, checked between clock edges.
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_an", {28'd0, an}, 32'hF);
      check("async_pattern", {28'd0, pattern}, 32'hF);
      check("async_frame", {28'd0, frame}, 32'd0);
      check("async_strobe", {31'd0, frame_strobe}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_pattern", {28'd0, pattern}, 32'd0);
      exp_frame_q.push_back(4'd8);
      wait_strobe(FRAME_CYC + 8, n);
      check("post_reset_cycles", n, FRAME_CYC);

      repeat (4) @(posedge clk);
      #1;
      check("frame_queue_empty", exp_frame_q.size(), 32'd0);
      check("an_queue_empty", exp_an_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
